// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared constants, FSM state type and carry-init helper for serial_alu
//
// Contents:
//   MODE_LOGIC / MODE_ARITH   : Mode encoding
//   SEL_A .. SEL_NOTAB        : Select encoding
//   state_e                   : IDLE / RUN / DONE controller states
//   init_carry()              : carry value loaded when an operation is accepted
package alu_pkg;

    localparam logic MODE_LOGIC = 1'b0;
    localparam logic MODE_ARITH = 1'b1;

    localparam logic [1:0] SEL_A     = 2'b00;
    localparam logic [1:0] SEL_NOTA  = 2'b01;
    localparam logic [1:0] SEL_AB    = 2'b10;
    localparam logic [1:0] SEL_NOTAB = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_e;

    // A+1, ~A+1 and ~A+B+1 all need the "+1" injected as the initial carry.
    // Only A+B starts from zero; logic mode never uses the carry.
    function automatic logic init_carry(input logic mode, input logic [1:0] sel);
        return (mode == MODE_ARITH) && (sel != SEL_AB);
    endfunction

endpackage

// File: rtl/alu_bit_slice.sv
// rtl/alu_bit_slice.sv - combinational 1-bit ALU slice used by serial_alu
//
// Ports:
//   a_i, b_i     : operand bits
//   c_i          : incoming carry (ignored in logic mode)
//   select_i     : operation select (bit 0 inverts a, bit 1 enables b)
//   mode_i       : 0 = logic, 1 = arithmetic
//   sum_o        : result bit
//   c_o          : outgoing carry (0 in logic mode)
module alu_bit_slice
    import alu_pkg::*;
(
    input  logic       a_i,
    input  logic       b_i,
    input  logic       c_i,
    input  logic [1:0] select_i,
    input  logic       mode_i,
    output logic       sum_o,
    output logic       c_o
);

    logic x;
    logic y;
    logic c_eff;

    assign x     = select_i[0] ? ~a_i : a_i;
    assign y     = select_i[1] ? b_i : 1'b0;
    // Logic mode masks the carry so the slice collapses to x ^ y.
    assign c_eff = (mode_i == MODE_ARITH) ? c_i : 1'b0;

    assign sum_o = x ^ y ^ c_eff;
    assign c_o   = (mode_i == MODE_ARITH) ? ((x & y) | (x & c_eff) | (y & c_eff)) : 1'b0;

endmodule

// File: rtl/serial_alu.sv
// rtl/serial_alu.sv - bit-serial ALU, one result bit per clock, LSB first
//
// Ports:
//   Clk, Reset            : clock, synchronous active-high reset
//   Start                 : request, sampled when not Busy
//   Select, Mode, A, B    : operation and operands, captured with Start
//   Busy                  : bits are being processed
//   Done                  : one-cycle pulse, Result/CarryOut/Zero valid
//   Result, CarryOut, Zero: held until the next completed operation
module serial_alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic [1:0]       Select,
    input  logic             Mode,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] Result,
    output logic             CarryOut,
    output logic             Zero
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_e state_q, state_d;

    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] a_sh_q;
    logic [WIDTH-1:0] b_sh_q;
    // Holds the WIDTH-1 bits already produced; the final bit is joined
    // combinationally on the last cycle.
    logic [WIDTH-2:0] res_sh_q;
    logic [1:0]       sel_q;
    logic             mode_q;
    logic             carry_q;
    logic             zacc_q;
    logic [WIDTH-1:0] result_q;
    logic             cout_q;
    logic             zero_q;

    logic             accept;
    logic             last_bit;
    logic             sum;
    logic             c_next;
    logic [WIDTH-1:0] res_full;

    assign accept   = Start && (state_q != ST_RUN);
    assign last_bit = (cnt_q == LAST_BIT);
    assign res_full = {sum, res_sh_q};

    alu_bit_slice u_slice (
        .a_i      (a_sh_q[0]),
        .b_i      (b_sh_q[0]),
        .c_i      (carry_q),
        .select_i (sel_q),
        .mode_i   (mode_q),
        .sum_o    (sum),
        .c_o      (c_next)
    );

    // State register
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; DONE accepts Start exactly like IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (Start) state_d = ST_RUN;
            ST_RUN:  if (last_bit) state_d = ST_DONE;
            ST_DONE: state_d = Start ? ST_RUN : ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs decoded from state
    always_comb begin
        Busy = 1'b0;
        Done = 1'b0;
        case (state_q)
            ST_RUN:  Busy = 1'b1;
            ST_DONE: Done = 1'b1;
            default: ;
        endcase
    end

    // Datapath: operand/result shift registers, carry, zero accumulator.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            cnt_q    <= '0;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            res_sh_q <= '0;
            sel_q    <= SEL_A;
            mode_q   <= MODE_LOGIC;
            carry_q  <= 1'b0;
            zacc_q   <= 1'b0;
            result_q <= '0;
            cout_q   <= 1'b0;
            zero_q   <= 1'b1;
        end else if (accept) begin
            cnt_q   <= '0;
            a_sh_q  <= A;
            b_sh_q  <= B;
            sel_q   <= Select;
            mode_q  <= Mode;
            carry_q <= init_carry(Mode, Select);
            zacc_q  <= 1'b0;
        end else if (state_q == ST_RUN) begin
            cnt_q    <= cnt_q + 1'b1;
            a_sh_q   <= a_sh_q >> 1;
            b_sh_q   <= b_sh_q >> 1;
            res_sh_q <= res_full[WIDTH-1:1];
            carry_q  <= c_next;
            zacc_q   <= zacc_q | sum;
            if (last_bit) begin
                result_q <= res_full;
                cout_q   <= (mode_q == MODE_ARITH) ? c_next : 1'b0;
                zero_q   <= ~(zacc_q | sum);
            end
        end
    end

    assign Result   = result_q;
    assign CarryOut = cout_q;
    assign Zero     = zero_q;

endmodule
